// File: rtl/vga_sprite_compositor.sv
// Per-pixel compositor for 8 hardware sprites over the VGA background.
// Double-buffered sprite parameters, 3-stage hit-test / fetch / merge pipeline.
module vga_sprite_compositor #(
  parameter int          NSPR    = 8,
  parameter logic [15:0] KEY_RST = 16'hF81F
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           avs_address,
  input  logic                 avs_read,
  output logic [31:0]          avs_readdata,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  input  logic                 frame_start,
  input  logic                 pix_valid,
  input  logic [9:0]           draw_x,
  input  logic [9:0]           draw_y,
  input  logic [15:0]          bg_val,
  output logic [11*NSPR-1:0]   spr_address,
  output logic [NSPR-1:0]      spr_chipselect,
  output logic                 spr_clken,
  input  logic [16*NSPR-1:0]   spr_readdata,
  output logic [15:0]          out_val,
  output logic                 out_valid
);

  localparam logic [7:0] ADDR_CTRL   = 8'h80;
  localparam logic [7:0] ADDR_STATUS = 8'h81;
  localparam logic [7:0] ADDR_KEY    = 8'h82;

  logic [9:0]      sh_x  [NSPR];
  logic [9:0]      sh_y  [NSPR];
  logic [5:0]      sh_w  [NSPR];
  logic [6:0]      sh_h  [NSPR];
  logic [NSPR-1:0] sh_en;
  logic [NSPR-1:0] sh_hf;

  logic [9:0]      act_x [NSPR];
  logic [9:0]      act_y [NSPR];
  logic [5:0]      act_w [NSPR];
  logic [6:0]      act_h [NSPR];
  logic [NSPR-1:0] act_en;
  logic [NSPR-1:0] act_hf;

  logic [15:0] key;
  logic [15:0] frame_cnt;
  logic        commit_pending;

  logic        spr_wr;
  logic [2:0]  spr_idx;
  logic [1:0]  spr_reg;
  logic        ctrl_set;
  logic        commit;
  logic [31:0] rd_next;
  logic        unused_wdata;

  assign spr_wr   = avs_write && (avs_address[7:5] == 3'b000);
  assign spr_idx  = avs_address[4:2];
  assign spr_reg  = avs_address[1:0];
  assign ctrl_set = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[0];
  // A commit write landing on frame_start is honoured on that same edge.
  assign commit   = frame_start && (commit_pending || ctrl_set);

  assign unused_wdata = ^avs_writedata[31:26];
  assign spr_clken    = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSPR; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        sh_w[i]  <= '0;
        sh_h[i]  <= '0;
        act_x[i] <= '0;
        act_y[i] <= '0;
        act_w[i] <= '0;
        act_h[i] <= '0;
      end
      sh_en          <= '0;
      sh_hf          <= '0;
      act_en         <= '0;
      act_hf         <= '0;
      key            <= KEY_RST;
      commit_pending <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      // Active set takes the pre-write shadow values when a write coincides.
      if (commit) begin
        for (int i = 0; i < NSPR; i++) begin
          act_x[i] <= sh_x[i];
          act_y[i] <= sh_y[i];
          act_w[i] <= sh_w[i];
          act_h[i] <= sh_h[i];
        end
        act_en <= sh_en;
        act_hf <= sh_hf;
      end
      if (spr_wr) begin
        case (spr_reg)
          2'd0: begin
            sh_x[spr_idx] <= avs_writedata[9:0];
            sh_y[spr_idx] <= avs_writedata[25:16];
          end
          2'd1: begin
            sh_w[spr_idx] <= avs_writedata[5:0];
            sh_h[spr_idx] <= avs_writedata[22:16];
          end
          2'd2: begin
            sh_en[spr_idx] <= avs_writedata[0];
            sh_hf[spr_idx] <= avs_writedata[1];
          end
          default: ;
        endcase
      end
      if (avs_write && (avs_address == ADDR_KEY))
        key <= avs_writedata[15:0];
      if (commit)
        commit_pending <= 1'b0;
      else if (ctrl_set)
        commit_pending <= 1'b1;
      if (frame_start)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_next = '0;
    if (avs_address[7:5] == 3'b000) begin
      case (spr_reg)
        2'd0:    rd_next = {6'b0, sh_y[spr_idx], 6'b0, sh_x[spr_idx]};
        2'd1:    rd_next = {9'b0, sh_h[spr_idx], 10'b0, sh_w[spr_idx]};
        2'd2:    rd_next = {30'b0, sh_hf[spr_idx], sh_en[spr_idx]};
        default: rd_next = '0;
      endcase
    end else begin
      case (avs_address)
        ADDR_CTRL:   rd_next = {31'b0, commit_pending};
        ADDR_STATUS: rd_next = {frame_cnt, 15'b0, commit_pending};
        ADDR_KEY:    rd_next = {16'b0, key};
        default:     rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      avs_readdata <= '0;
    else if (avs_read)
      avs_readdata <= rd_next;
  end

  logic [NSPR-1:0] hit_c;
  logic [10:0]     addr_c [NSPR];

  for (genvar g = 0; g < NSPR; g++) begin : g_hit
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [5:0]  dx_raw;
    logic [5:0]  dx;
    logic [6:0]  dy;
    logic [10:0] prod;

    assign x_end = {1'b0, act_x[g]} + {5'b0, act_w[g]};
    assign y_end = {1'b0, act_y[g]} + {4'b0, act_h[g]};
    assign hit_c[g] = act_en[g] &&
                      (draw_x >= act_x[g]) && ({1'b0, draw_x} < x_end) &&
                      (draw_y >= act_y[g]) && ({1'b0, draw_y} < y_end);
    // Only the low bits of the offsets matter once the pixel is inside the sprite.
    assign dx_raw = draw_x[5:0] - act_x[g][5:0];
    assign dy     = draw_y[6:0] - act_y[g][6:0];
    assign dx     = act_hf[g] ? (act_w[g] - 6'd1 - dx_raw) : dx_raw;
    assign prod   = {4'b0, dy} * {5'b0, act_w[g]};
    assign addr_c[g] = prod + {5'b0, dx};
  end

  logic [15:0]        bg_s1;
  logic               valid_s1;
  logic [16*NSPR-1:0] rd_s2;
  logic [NSPR-1:0]    hit_s2;
  logic [15:0]        bg_s2;
  logic               valid_s2;
  logic [15:0]        pix_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spr_address    <= '0;
      spr_chipselect <= '0;
      bg_s1          <= '0;
      valid_s1       <= 1'b0;
      rd_s2          <= '0;
      hit_s2         <= '0;
      bg_s2          <= '0;
      valid_s2       <= 1'b0;
      out_val        <= '0;
      out_valid      <= 1'b0;
    end else begin
      if (pix_valid) begin
        for (int i = 0; i < NSPR; i++)
          spr_address[11*i +: 11] <= addr_c[i];
      end
      spr_chipselect <= pix_valid ? hit_c : '0;
      bg_s1          <= bg_val;
      valid_s1       <= pix_valid;
      rd_s2          <= spr_readdata;
      hit_s2         <= spr_chipselect;
      bg_s2          <= bg_s1;
      valid_s2       <= valid_s1;
      out_val        <= pix_c;
      out_valid      <= valid_s2;
    end
  end

  // Scan high to low so the lowest-index opaque sprite ends up on top.
  always_comb begin
    pix_c = bg_s2;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (hit_s2[i] && (rd_s2[16*i +: 16] != key))
        pix_c = rd_s2[16*i +: 16];
    end
  end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor: register model, sprite RAM model
// and a scoreboard of expected composited pixels with their arrival cycle.
module tb_vga_sprite_compositor;
  localparam int NSPR = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [7:0]         avs_address;
  logic               avs_read;
  logic [31:0]        avs_readdata;
  logic               avs_write;
  logic [31:0]        avs_writedata;
  logic               frame_start;
  logic               pix_valid;
  logic [9:0]         draw_x;
  logic [9:0]         draw_y;
  logic [15:0]        bg_val;
  logic [11*NSPR-1:0] spr_address;
  logic [NSPR-1:0]    spr_chipselect;
  logic               spr_clken;
  logic [16*NSPR-1:0] spr_readdata;
  logic [15:0]        out_val;
  logic               out_valid;

  vga_sprite_compositor #(.NSPR(NSPR), .KEY_RST(16'hF81F)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .frame_start(frame_start), .pix_valid(pix_valid),
    .draw_x(draw_x), .draw_y(draw_y), .bg_val(bg_val),
    .spr_address(spr_address), .spr_chipselect(spr_chipselect),
    .spr_clken(spr_clken), .spr_readdata(spr_readdata),
    .out_val(out_val), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [NSPR][2048];
  for (genvar g = 0; g < NSPR; g++) begin : g_ram
    assign spr_readdata[16*g +: 16] = mem[g][spr_address[11*g +: 11]];
  end

  int n_vec = 0;
  int n_err = 0;

  int sh_x[NSPR], sh_y[NSPR], sh_w[NSPR], sh_h[NSPR], sh_en[NSPR], sh_hf[NSPR];
  int ac_x[NSPR], ac_y[NSPR], ac_w[NSPR], ac_h[NSPR], ac_en[NSPR], ac_hf[NSPR];
  logic [15:0] key;
  int pend;
  int fcount;

  typedef struct {
    logic [15:0] val;
    int          at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int x, input int y, input logic [15:0] bg);
    for (int i = 0; i < NSPR; i++) begin
      if (ac_en[i] != 0 && x >= ac_x[i] && x < ac_x[i] + ac_w[i] &&
          y >= ac_y[i] && y < ac_y[i] + ac_h[i]) begin
        int dx;
        int a;
        dx = x - ac_x[i];
        if (ac_hf[i] != 0) dx = ac_w[i] - 1 - dx;
        a = ((y - ac_y[i]) * ac_w[i] + dx) & 2047;
        if (mem[i][a] != key) return mem[i][a];
      end
    end
    return bg;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSPR; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0; sh_en[i] = 0; sh_hf[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_w[i] = 0; ac_h[i] = 0; ac_en[i] = 0; ac_hf[i] = 0;
    end
    key = 16'hF81F;
    pend = 0;
    fcount = 0;
  endtask

  // One bus cycle, optionally with a frame_start pulse on the same edge.
  task automatic bus(input bit wr, input bit rd, input bit fs,
                     input logic [7:0] a, input logic [31:0] d);
    bit ctrl;
    int idx;
    @(negedge clk);
    pix_valid = 1'b0;
    avs_write = wr; avs_read = rd; frame_start = fs;
    avs_address = a; avs_writedata = d;
    @(posedge clk);
    ctrl = wr && a == 8'h80 && d[0];
    if (fs && (pend != 0 || ctrl)) begin
      for (int i = 0; i < NSPR; i++) begin
        ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_w[i] = sh_w[i];
        ac_h[i] = sh_h[i]; ac_en[i] = sh_en[i]; ac_hf[i] = sh_hf[i];
      end
      pend = 0;
    end else if (ctrl) begin
      pend = 1;
    end
    if (wr && a[7:5] == 3'b000) begin
      idx = int'(a[4:2]);
      case (a[1:0])
        2'd0: begin sh_x[idx] = int'(d[9:0]); sh_y[idx] = int'(d[25:16]); end
        2'd1: begin sh_w[idx] = int'(d[5:0]); sh_h[idx] = int'(d[22:16]); end
        2'd2: begin sh_en[idx] = int'(d[0]); sh_hf[idx] = int'(d[1]); end
        default: ;
      endcase
    end
    if (wr && a == 8'h82) key = d[15:0];
    if (fs) fcount = (fcount + 1) & 16'hFFFF;
    #1;
    avs_write = 1'b0; avs_read = 1'b0; frame_start = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, 1'b0, a, d);
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string tag);
    bus(1'b0, 1'b1, 1'b0, a, 32'h0);
    check(avs_readdata, exp, tag);
  endtask

  task automatic frame();
    bus(1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
  endtask

  task automatic pixel(input int x, input int y, input logic [15:0] bg);
    @(negedge clk);
    pix_valid = 1'b1;
    draw_x = 10'(x); draw_y = 10'(y); bg_val = bg;
    sb.push_back('{model(x, y, bg), cyc + 3});
  endtask

  task automatic s1_chk(input bit chk_addr, input logic [10:0] exp_addr,
                        input logic exp_cs, input string tag);
    @(posedge clk);
    #1;
    if (chk_addr) check(32'(spr_address[10:0]), 32'(exp_addr), {tag, "_addr"});
    check(32'(spr_chipselect[0]), 32'(exp_cs), {tag, "_cs"});
  endtask

  task automatic drain();
    @(negedge clk);
    pix_valid = 1'b0;
    for (int k = 0; k < 12 && sb.size() > 0; k++) @(negedge clk);
    check(32'(sb.size()), 32'd0, "drain_outstanding");
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_output: observed %h expected no output", out_val);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check(32'(out_val), 32'(e.val), "pixel_val");
        check(32'(cyc), 32'(e.at), "pixel_latency");
      end
    end
  end

  initial begin
    logic [31:0] exp_status;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    frame_start = 0; pix_valid = 0; draw_x = '0; draw_y = '0; bg_val = '0;
    for (int i = 0; i < NSPR; i++)
      for (int a = 0; a < 2048; a++)
        mem[i][a] = 16'((i << 13) | (1 << 11) | a);
    mem[0][35] = 16'hABCD;
    mem[0][44] = 16'hF81F;
    mem[0][52] = 16'h1111;
    mem[3][52] = 16'h3333;
    mem[0][53] = 16'hF81F;
    mem[3][53] = 16'h3334;
    model_reset();

    repeat (3) @(negedge clk);
    check(32'(out_valid), 32'd0, "rst_out_valid");
    check(32'(out_val), 32'd0, "rst_out_val");
    check(avs_readdata, 32'd0, "rst_readdata");
    check(32'(spr_chipselect), 32'd0, "rst_cs");
    check(32'(spr_clken), 32'd1, "clken");
    reset = 1'b0;

    // Background pass-through with a gap in pix_valid.
    pixel(0, 0, 16'h1234); pixel(1, 0, 16'h1234); pixel(2, 0, 16'h1234);
    @(negedge clk); pix_valid = 1'b0;
    pixel(3, 0, 16'h1234); pixel(4, 0, 16'h1234);
    drain();
    rd_chk(8'h81, 32'h0, "status_after_reset");
    rd_chk(8'h82, 32'h0000F81F, "key_reset");
    rd_chk(8'h80, 32'h0, "ctrl_reset");

    // Sprite 0 at (100,50) 16x16.
    wr(8'h00, (32'd50 << 16) | 32'd100);
    wr(8'h01, (32'd16 << 16) | 32'd16);
    wr(8'h02, 32'd1);
    wr(8'h80, 32'd1);
    rd_chk(8'h80, 32'd1, "ctrl_pending");
    frame();
    rd_chk(8'h80, 32'd0, "ctrl_after_frame");
    rd_chk(8'h01, 32'h00100010, "reg1_readback");
    rd_chk(8'h03, 32'h0, "reg3_zero");
    rd_chk(8'h90, 32'h0, "unmapped_zero");
    pixel(103, 52, 16'h5555); s1_chk(1, 11'd35, 1'b1, "hit_103_52");
    pixel(116, 52, 16'h5555); s1_chk(0, 11'd0, 1'b0, "miss_right");
    pixel(99, 52, 16'h5555);  s1_chk(0, 11'd0, 1'b0, "miss_left");
    pixel(115, 65, 16'h5555); s1_chk(1, 11'd255, 1'b1, "hit_corner");
    pixel(103, 66, 16'h5555); s1_chk(0, 11'd0, 1'b0, "miss_below");
    pixel(100, 50, 16'h5555); s1_chk(1, 11'd0, 1'b1, "hit_origin");
    @(negedge clk); pix_valid = 1'b0; draw_x = 10'd115; draw_y = 10'd65;
    @(posedge clk); #1;
    check(32'(spr_address[10:0]), 32'd0, "idle_addr_hold");
    check(32'(spr_chipselect), 32'd0, "idle_cs");
    drain();

    // Horizontal flip; flipped texel is the key colour.
    wr(8'h02, 32'd3);
    wr(8'h80, 32'd1);
    frame();
    pixel(103, 52, 16'h2222); s1_chk(1, 11'd44, 1'b1, "hflip_addr");
    pixel(100, 50, 16'h2222); s1_chk(1, 11'd15, 1'b1, "hflip_origin");
    drain();

    // Sprites 0 and 3 overlapping.
    wr(8'h02, 32'd1);
    wr(8'h0C, (32'd50 << 16) | 32'd100);
    wr(8'h0D, (32'd16 << 16) | 32'd16);
    wr(8'h0E, 32'd1);
    wr(8'h80, 32'd1);
    frame();
    pixel(104, 53, 16'h7777);
    @(posedge clk); #1;
    check(32'(spr_chipselect), 32'h09, "overlap_cs");
    check(32'(spr_address[43:33]), 32'd52, "spr3_addr");
    pixel(105, 53, 16'h7777);
    drain();
    wr(8'h82, 32'h1111);
    pixel(104, 53, 16'h7777);
    drain();
    wr(8'h82, 32'hF81F);

    // Shadow writes stay invisible until a committed frame.
    wr(8'h00, (32'd50 << 16) | 32'd200);
    pixel(103, 52, 16'h6666); pixel(203, 52, 16'h6666);
    drain();
    wr(8'h80, 32'd1);
    rd_chk(8'h80, 32'd1, "ctrl_pending2");
    frame();
    rd_chk(8'h80, 32'd0, "ctrl_cleared2");
    pixel(203, 52, 16'h6666); pixel(103, 52, 16'h6666);
    drain();

    // Shadow write on the commit edge: active keeps the pre-write value.
    wr(8'h80, 32'd1);
    bus(1'b1, 1'b0, 1'b1, 8'h00, (32'd50 << 16) | 32'd400);
    rd_chk(8'h80, 32'd0, "ctrl_after_collide");
    rd_chk(8'h00, 32'h00320190, "shadow_new_x");
    pixel(403, 52, 16'h4444); pixel(203, 52, 16'h4444);
    drain();

    // Commit write on the frame_start edge is honoured immediately.
    bus(1'b1, 1'b0, 1'b1, 8'h80, 32'd1);
    rd_chk(8'h80, 32'd0, "ctrl_same_edge");
    pixel(403, 52, 16'h4444);
    drain();

    exp_status = {16'(fcount), 15'b0, 1'b0};
    bus(1'b0, 1'b1, 1'b1, 8'h81, 32'h0);
    check(avs_readdata, exp_status, "status_pre_increment");
    rd_chk(8'h81, {16'(fcount), 16'h0}, "status_post_increment");

    // Reset while pixels are in flight.
    for (int i = 0; i < 6; i++) pixel(403 + i, 52, 16'h0F0F);
    @(negedge clk); pix_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    check(32'(out_valid), 32'd1, "ov_before_reset");
    reset = 1'b1;
    #1;
    check(32'(out_valid), 32'd0, "ov_async_reset");
    check(32'(out_val), 32'd0, "oval_async_reset");
    check(32'(spr_chipselect), 32'd0, "cs_async_reset");
    check(32'(spr_address[10:0]), 32'd0, "addr_async_reset");
    sb.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    pixel(403, 52, 16'h0A0A); s1_chk(0, 11'd0, 1'b0, "disabled_after_reset");
    drain();
    rd_chk(8'h00, 32'h0, "reg0_after_reset");
    rd_chk(8'h82, 32'h0000F81F, "key_after_reset");

    // frame_cnt wrap.
    @(negedge clk);
    frame_start = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    frame_start = 1'b0;
    fcount = 65535;
    rd_chk(8'h81, 32'hFFFF0000, "status_ffff");
    frame();
    rd_chk(8'h81, 32'h0, "status_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
